// File: rtl/slow_memory_mc.sv
// Shared slow line memory serving NUM_CH requesters through a round-robin arbiter.
// One transaction at a time: grant in IDLE, LATENCY-cycle wait in BUSY, one-cycle ready in DONE.
module slow_memory_mc #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [NUM_CH*LINE_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [LINE_W-1:0] mem [DEPTH];

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt;
  logic              is_wr;
  logic [IDX_W-1:0]  idx;
  logic [LINE_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_CH-1:0] req;
  logic              found;
  logic [CH_W-1:0]   pick;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_err;
  logic              gnt_req;
  logic [CH_W-1:0]   next_ptr;

  assign req = ch_read | ch_write;

  // First requester at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        pick  = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  assign pick_addr = ch_addr[int'(pick)*ADDR_W +: ADDR_W];
  // Upper address bits are ignored for indexing but flag a protocol error.
  assign pick_err  = (ch_read[pick] && ch_write[pick]) || ((pick_addr >> IDX_W) != '0);
  assign gnt_req   = ch_read[gnt] | ch_write[gnt];
  assign next_ptr  = CH_W'((int'(gnt) + 1) % NUM_CH);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      is_wr     <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      ch_ready  <= '0;
      ch_rdata  <= '0;
      proto_err <= 1'b0;
    end else begin
      ch_ready <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= pick;
            is_wr   <= ch_write[pick];
            idx     <= pick_addr[IDX_W-1:0];
            wdata_q <= ch_wdata[int'(pick)*LINE_W +: LINE_W];
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
            if (pick_err) proto_err <= 1'b1;
          end
        end
        BUSY: begin
          if (!gnt_req) proto_err <= 1'b1;
          if (cnt == '0) begin
            state         <= DONE;
            ch_ready[gnt] <= 1'b1;
            if (!is_wr) ch_rdata[int'(gnt)*LINE_W +: LINE_W] <= mem[idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces state out of DONE asynchronously, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (state == DONE && is_wr) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_slow_memory_mc.sv
// Bench for slow_memory_mc: directed steps plus randomized traffic against a
// transaction-level model (round-robin grant, fixed latency, sticky error, line array).
module tb_slow_memory_mc;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int LW = 128;
  localparam int L  = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    ch_read = '0;
  logic [N-1:0]    ch_write = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N*LW-1:0] ch_wdata = '0;
  logic [N*LW-1:0] ch_rdata;
  logic [N-1:0]    ch_ready;
  logic            busy;
  logic            proto_err;

  int vectors = 0;
  int miscompares = 0;

  logic [LW-1:0] m_mem [256];
  bit            m_valid [256];
  logic [LW-1:0] m_rdata [N];
  int            m_ptr;
  bit            m_err;

  int            d_op [N];
  logic [AW-1:0] d_addr [N];
  logic [LW-1:0] d_data [N];
  logic [LW-1:0] old_line, new_line;

  always #5 clk = ~clk;

  slow_memory_mc #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .DEPTH(256), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_ready(ch_ready),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [N*LW-1:0] obs, input logic [N*LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*LW-1:0] exp_rdata();
    logic [N*LW-1:0] r;
    for (int i = 0; i < N; i++) r[i*LW +: LW] = m_rdata[i];
    return r;
  endfunction

  // op: 0 read, 1 write, 3 read+write
  task automatic drive(input int i, input int op, input logic [AW-1:0] a, input logic [LW-1:0] d);
    ch_read[i]  = (op != 1);
    ch_write[i] = (op != 0);
    ch_addr[i*AW +: AW]  = a;
    ch_wdata[i*LW +: LW] = d;
  endtask

  task automatic rand_req(input int i);
    logic [AW-1:0] a;
    int op;
    a = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) a[24] = 1'b1;
    if (!m_valid[a[7:0]]) op = 1;
    else if ($urandom_range(0, 9) == 0) op = 3;
    else op = int'($urandom_range(0, 1));
    drive(i, op, a, {$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_err = 1'b0;
    for (int i = 0; i < N; i++) m_rdata[i] = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, ch_ready, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, proto_err, 1'b0);
    chk({tag, "_rdata"}, ch_rdata, exp_rdata());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    ch_read = '0;
    ch_write = '0;
    model_reset();
    #1 check_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Keeps channels in mask requesting until each has completed per_ch transactions.
  // The first request of each channel uses d_op/d_addr/d_data unless d_op is negative.
  // drop_ch (if >= 0) releases its request three cycles into its first transaction.
  task automatic engine(input logic [N-1:0] mask, input int per_ch, input int drop_ch);
    int left [N];
    bit inflight, finished, found;
    int c, g, gt, g_idx, restart, restart_c, err_at;
    bit g_wr;
    logic [LW-1:0] g_data;
    logic [AW-1:0] a;
    logic [N-1:0] req, exp_ready;
    inflight = 1'b0; finished = 1'b0;
    c = 0; g = 0; gt = 0; g_idx = 0; g_wr = 1'b0; g_data = '0;
    restart = -1; restart_c = 0; err_at = -1;
    for (int i = 0; i < N; i++) begin
      left[i] = mask[i] ? per_ch : 0;
      if (mask[i]) begin
        if (d_op[i] < 0) rand_req(i);
        else drive(i, d_op[i], d_addr[i], d_data[i]);
      end
    end
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      c++;
      req = ch_read | ch_write;
      if (!inflight && req != '0) begin
        found = 1'b0;
        for (int s = 0; s < N; s++) begin
          if (!found && req[(m_ptr + s) % N]) begin
            found = 1'b1;
            g = (m_ptr + s) % N;
          end
        end
        a      = ch_addr[g*AW +: AW];
        g_wr   = ch_write[g];
        g_idx  = int'(a % 256);
        g_data = ch_wdata[g*LW +: LW];
        if ((ch_read[g] && ch_write[g]) || (a >> 8) != 0) m_err = 1'b1;
        inflight = 1'b1;
        gt = c;
      end
      #1;
      if (err_at == c) m_err = 1'b1;
      exp_ready = '0;
      if (inflight && c == gt + L) begin
        exp_ready[g] = 1'b1;
        if (g_wr) begin
          m_mem[g_idx] = g_data;
          m_valid[g_idx] = 1'b1;
        end else begin
          m_rdata[g] = m_mem[g_idx];
        end
      end
      chk("ready", ch_ready, exp_ready);
      chk("busy", busy, inflight && c <= gt + L);
      chk("proto_err", proto_err, m_err);
      chk("rdata", ch_rdata, exp_rdata());
      if (inflight && g == drop_ch && c == gt + 3) begin
        drive(g, 0, AW'($urandom()), {4{$urandom()}});
        ch_read[g] = 1'b0;
        err_at = c + 1;
      end
      if (inflight && c == gt + L + 1) begin
        ch_read[g] = 1'b0;
        ch_write[g] = 1'b0;
        inflight = 1'b0;
        m_ptr = (g + 1) % N;
        left[g]--;
        if (left[g] > 0) begin
          restart = g;
          restart_c = c + 1;
        end
      end else if (restart >= 0 && c == restart_c) begin
        rand_req(restart);
        restart = -1;
      end
      if (!inflight && restart < 0 && left.sum() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      vectors++;
      miscompares++;
      $error("FAIL engine_timeout: observed no completion expected all %0d transactions done", per_ch);
    end
    for (int i = 0; i < N; i++) d_op[i] = -1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) d_op[i] = -1;
    model_reset();
    old_line = {$urandom(), $urandom(), $urandom(), $urandom()};
    new_line = ~old_line;

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("por");
    rst = 1'b0;

    // Preload line 5 through ch1, then ch0 reads it with the nominal latency
    d_op[1] = 1; d_addr[1] = 28'd5; d_data[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    engine(4'b0010, 1, -1);
    d_op[0] = 0; d_addr[0] = 28'd5;
    engine(4'b0001, 1, -1);

    // Write from one channel is visible to another; writer's rdata untouched
    d_op[1] = 1; d_addr[1] = 28'd7; d_data[1] = 128'hDEAD0000_11112222_33334444_0000BEEF;
    engine(4'b0010, 1, -1);
    d_op[0] = 0; d_addr[0] = 28'd7;
    engine(4'b0001, 1, -1);

    // Simultaneous ch0/ch1 after reset: alternating service, LATENCY+2 apart
    do_reset();
    engine(4'b0011, 2, -1);

    // Read and write together: write wins and the error is sticky
    d_op[0] = 3; d_addr[0] = 28'd11; d_data[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    engine(4'b0001, 1, -1);
    d_op[2] = 0; d_addr[2] = 28'd11;
    engine(4'b0100, 1, -1);

    // Reset in the middle of a write aborts it
    do_reset();
    d_op[1] = 1; d_addr[1] = 28'd9; d_data[1] = old_line;
    engine(4'b0010, 1, -1);
    drive(3, 1, 28'd9, new_line);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    model_reset();
    #1 chk("abort_busy", busy, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("abort_ready", ch_ready, '0);
    end
    ch_read = '0;
    ch_write = '0;
    rst = 1'b0;
    d_op[0] = 0; d_addr[0] = 28'd9;
    d_op[2] = 0; d_addr[2] = 28'd9;
    engine(4'b0101, 1, -1);

    // Granted channel drops its request mid-transaction
    d_op[2] = 0; d_addr[2] = 28'd5;
    engine(4'b0100, 1, 2);

    // Upper address bits wrap to the index
    do_reset();
    d_op[1] = 1; d_addr[1] = 28'h0100006; d_data[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    engine(4'b0010, 1, -1);
    d_op[3] = 0; d_addr[3] = 28'd6;
    engine(4'b1000, 1, -1);

    // All four channels requesting continuously with random traffic
    do_reset();
    engine(4'b1111, 3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
